// File: rtl/isram_ctrl_if.sv
// Fetch and load/store side of the instruction-SRAM controller.
// The requesting core drives through master; isram_ctrl responds through slave.
interface isram_ctrl_if;
   logic        isram_cs;
   logic [31:3] isram_adr;
   logic [63:0] instr_fromsram;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_adr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_be;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic        lr_isram_cs;
   logic        lr_isram_cs_ff;

   modport master (
      output isram_cs, isram_adr, lsu_req, lsu_we, lsu_adr, lsu_wdata, lsu_be,
      input  instr_fromsram, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
             lr_isram_cs, lr_isram_cs_ff
   );

   modport slave (
      input  isram_cs, isram_adr, lsu_req, lsu_we, lsu_adr, lsu_wdata, lsu_be,
      output instr_fromsram, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
             lr_isram_cs, lr_isram_cs_ff
   );
endinterface

// File: rtl/isram_ctrl.sv
// Single-port 64-bit ISRAM arbiter: fetch reads by default, LSU steals the macro
// for a fixed two-cycle access followed by at least one fetch slot.
module isram_ctrl #(
   parameter int unsigned ISRAM_AW   = 13,
   parameter logic [31:0] ISRAM_BASE = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                cpurst_n,
   isram_ctrl_if.slave         bus,
   output logic                mem_cs,
   output logic                mem_we,
   output logic [ISRAM_AW-1:0] mem_adr,
   output logic [63:0]         mem_wdata,
   output logic [7:0]          mem_bwe,
   input  logic [63:0]         mem_rdata
);
   typedef enum logic [1:0] {IDLE, LS_ACC, LS_RSP} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_we;
   logic [ISRAM_AW+2:2]   r_adr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic                  r_err;
   logic                  r_lr_cs;
   logic                  r_lr_cs_ff;
   logic [31:0]           w_offset;
   logic                  w_err;
   logic                  w_unused;

   // Region check uses 32-bit wrap so addresses below the base also error.
   assign w_offset = bus.lsu_adr - ISRAM_BASE;
   assign w_err    = (w_offset >> (ISRAM_AW + 3)) != 32'd0;
   assign w_unused = ^{bus.isram_adr[31:ISRAM_AW+3], bus.lsu_adr[1:0]};

   assign bus.instr_fromsram = mem_rdata;
   assign bus.lr_isram_cs    = r_lr_cs;
   assign bus.lr_isram_cs_ff = r_lr_cs_ff;
   assign mem_wdata          = {r_wdata, r_wdata};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bwe
         localparam bit HI_LANE = (gi >= 4);
         assign mem_bwe[gi] = (r_adr[2] == HI_LANE) && r_be[gi % 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_adr      <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_err      <= 1'b0;
         r_lr_cs    <= 1'b0;
         r_lr_cs_ff <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_lr_cs    <= (w_state_next != IDLE);
         r_lr_cs_ff <= r_lr_cs;
         if (r_state == IDLE && bus.lsu_req) begin
            r_we    <= bus.lsu_we;
            r_adr   <= bus.lsu_adr[ISRAM_AW+2:2];
            r_wdata <= bus.lsu_wdata;
            r_be    <= bus.lsu_be;
            r_err   <= w_err;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      bus.lsu_gnt    = 1'b0;
      bus.lsu_rvalid = 1'b0;
      bus.lsu_err    = 1'b0;
      bus.lsu_rdata  = 32'd0;
      mem_cs         = 1'b0;
      mem_we         = 1'b0;
      mem_adr        = r_adr[ISRAM_AW+2:3];
      case (r_state)
         IDLE: begin
            bus.lsu_gnt = bus.lsu_req;
            mem_cs      = bus.isram_cs;
            mem_adr     = bus.isram_adr[ISRAM_AW+2:3];
            if (bus.lsu_req) w_state_next = LS_ACC;
         end
         LS_ACC: begin
            mem_cs       = ~r_err;
            mem_we       = r_we;
            w_state_next = LS_RSP;
         end
         LS_RSP: begin
            bus.lsu_rvalid = 1'b1;
            bus.lsu_err    = r_err;
            if (!r_we && !r_err)
               bus.lsu_rdata = r_adr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_isram_ctrl.sv
// Scenario bench for isram_ctrl: behavioural SRAM macro plus scoreboards for
// fetch words and LSU responses.
module tb_isram_ctrl;
   logic        clk = 1'b0;
   logic        cpurst_n = 1'b0;
   logic        mem_cs, mem_we;
   logic [12:0] mem_adr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [7:0]  mem_bwe;
   logic        pl_en = 1'b0;
   logic [12:0] pl_adr = '0;
   logic [63:0] pl_data = '0;
   logic [63:0] tb_mem [0:8191];

   typedef struct packed {logic [31:0] rdata; logic err;} lsu_exp_t;
   lsu_exp_t    lsu_q[$];
   logic [63:0] fetch_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   isram_ctrl_if bus ();

   isram_ctrl #(.ISRAM_AW(13), .ISRAM_BASE(32'h0000_0000)) dut (
      .clk(clk), .cpurst_n(cpurst_n), .bus(bus),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_bwe(mem_bwe), .mem_rdata(mem_rdata)
   );

   // Macro model: one-cycle registered read, byte-masked write.
   always @(posedge clk) begin
      if (pl_en) tb_mem[pl_adr] <= pl_data;
      else if (mem_cs) begin
         if (mem_we) begin
            for (int b = 0; b < 8; b++)
               if (mem_bwe[b]) tb_mem[mem_adr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else mem_rdata <= tb_mem[mem_adr];
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic settle(); @(negedge clk); endtask

   task automatic preload(input logic [12:0] a, input logic [63:0] d);
      pl_adr = a; pl_data = d; pl_en = 1'b1;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      bus.isram_cs = 0; bus.isram_adr = '0; bus.lsu_req = 0; bus.lsu_we = 0;
      bus.lsu_adr = '0; bus.lsu_wdata = '0; bus.lsu_be = '0;
      cpurst_n = 0;
      preload(13'h10, 64'h1122334455667788);
      preload(13'h1FFF, 64'hCAFEBABE_0BADF00D);
      settle();
      n_checks++; if (bus.lr_isram_cs !== 1'b0) $display("FAIL reset_lr got %b exp 0", bus.lr_isram_cs); else n_pass++;
      n_checks++; if (bus.lr_isram_cs_ff !== 1'b0) $display("FAIL reset_lr_ff got %b exp 0", bus.lr_isram_cs_ff); else n_pass++;
      n_checks++; if (bus.lsu_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b exp 0", bus.lsu_rvalid); else n_pass++;
      n_checks++; if (bus.lsu_err !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.lsu_err); else n_pass++;
      n_checks++; if (bus.lsu_rdata !== 32'd0) $display("FAIL reset_rdata got %h exp 0", bus.lsu_rdata); else n_pass++;
      n_checks++; if (mem_cs !== 1'b0) $display("FAIL reset_mem_cs got %b exp 0", mem_cs); else n_pass++;
      $display("reset: lr=%b lr_ff=%b rvalid=%b", bus.lr_isram_cs, bus.lr_isram_cs_ff, bus.lsu_rvalid);
      tick();
      cpurst_n = 1;
   endtask

   task automatic test_fetch();
      logic [28:0] adrs [2];
      adrs[0] = 29'h10;
      adrs[1] = 29'h10 | (29'h1 << 13);
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.isram_cs = 1; bus.isram_adr = adrs[i];
         settle();
         n_checks++; if (mem_cs !== 1'b1) $display("FAIL fetch_mem_cs got %b exp 1", mem_cs); else n_pass++;
         n_checks++; if (mem_adr !== 13'h10) $display("FAIL fetch_mem_adr got %h exp 010", mem_adr); else n_pass++;
         fetch_q.push_back(64'h1122334455667788);
         tick();
         bus.isram_cs = 0;
         settle();
         n_checks++;
         if (fetch_q.size() == 0) $display("FAIL fetch_sb empty");
         else begin
            logic [63:0] e;
            e = fetch_q.pop_front();
            if (bus.instr_fromsram !== e) $display("FAIL fetch_data got %h exp %h", bus.instr_fromsram, e);
            else n_pass++;
         end
         $display("fetch: adr=%h instr=%h", adrs[i], bus.instr_fromsram);
      end
   endtask

   task automatic test_lsu_read();
      tick();
      bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_adr = 32'h84;
      settle();
      n_checks++; if (bus.lsu_gnt !== 1'b1) $display("FAIL rd_gnt got %b exp 1", bus.lsu_gnt); else n_pass++;
      lsu_q.push_back('{rdata: 32'h11223344, err: 1'b0});
      tick();
      bus.lsu_req = 0;
      settle();
      n_checks++; if (bus.lr_isram_cs !== 1'b1) $display("FAIL rd_lr got %b exp 1", bus.lr_isram_cs); else n_pass++;
      n_checks++; if ({mem_cs, mem_we} !== 2'b10) $display("FAIL rd_cs_we got %b exp 10", {mem_cs, mem_we}); else n_pass++;
      n_checks++; if (mem_adr !== 13'h10) $display("FAIL rd_mem_adr got %h exp 010", mem_adr); else n_pass++;
      n_checks++; if (bus.lsu_gnt !== 1'b0) $display("FAIL rd_gnt_acc got %b exp 0", bus.lsu_gnt); else n_pass++;
      tick();
      settle();
      n_checks++; if (bus.lsu_rvalid !== 1'b1) $display("FAIL rd_rvalid got %b exp 1", bus.lsu_rvalid); else n_pass++;
      n_checks++;
      if (lsu_q.size() == 0) $display("FAIL rd_sb empty");
      else begin
         lsu_exp_t e;
         e = lsu_q.pop_front();
         if ({bus.lsu_rdata, bus.lsu_err} !== e) $display("FAIL rd_resp got %h/%b exp %h/%b", bus.lsu_rdata, bus.lsu_err, e.rdata, e.err);
         else n_pass++;
      end
      n_checks++; if (bus.lr_isram_cs_ff !== 1'b1) $display("FAIL rd_lr_ff_t2 got %b exp 1", bus.lr_isram_cs_ff); else n_pass++;
      $display("lsu_read: adr=00000084 rdata=%h err=%b", bus.lsu_rdata, bus.lsu_err);
      tick();
      settle();
      n_checks++; if ({bus.lr_isram_cs, bus.lr_isram_cs_ff} !== 2'b01) $display("FAIL rd_lr_t3 got %b exp 01", {bus.lr_isram_cs, bus.lr_isram_cs_ff}); else n_pass++;
      n_checks++; if (bus.lsu_rvalid !== 1'b0) $display("FAIL rd_rvalid_t3 got %b exp 0", bus.lsu_rvalid); else n_pass++;
   endtask

   task automatic test_lsu_write();
      tick();
      bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_adr = 32'h80; bus.lsu_be = 4'b0011; bus.lsu_wdata = 32'hAABBCCDD;
      settle();
      n_checks++; if (bus.lsu_gnt !== 1'b1) $display("FAIL wr_gnt got %b exp 1", bus.lsu_gnt); else n_pass++;
      lsu_q.push_back('{rdata: 32'h0, err: 1'b0});
      tick();
      bus.lsu_req = 0; bus.lsu_we = 0;
      settle();
      n_checks++; if ({mem_cs, mem_we} !== 2'b11) $display("FAIL wr_cs_we got %b exp 11", {mem_cs, mem_we}); else n_pass++;
      n_checks++; if (mem_bwe !== 8'h03) $display("FAIL wr_bwe got %h exp 03", mem_bwe); else n_pass++;
      n_checks++; if (mem_wdata !== 64'hAABBCCDDAABBCCDD) $display("FAIL wr_wdata got %h exp aabbccddaabbccdd", mem_wdata); else n_pass++;
      tick();
      settle();
      n_checks++; if (bus.lsu_rvalid !== 1'b1) $display("FAIL wr_rvalid got %b exp 1", bus.lsu_rvalid); else n_pass++;
      n_checks++;
      if (lsu_q.size() == 0) $display("FAIL wr_sb empty");
      else begin
         lsu_exp_t e;
         e = lsu_q.pop_front();
         if ({bus.lsu_rdata, bus.lsu_err} !== e) $display("FAIL wr_resp got %h/%b exp %h/%b", bus.lsu_rdata, bus.lsu_err, e.rdata, e.err);
         else n_pass++;
      end
      $display("lsu_write: adr=00000080 be=3 rdata=%h", bus.lsu_rdata);
      // Read the doubleword back through fetch to confirm only the low two bytes changed.
      tick();
      bus.isram_cs = 1; bus.isram_adr = 29'h10;
      fetch_q.push_back(64'h112233445566CCDD);
      tick();
      bus.isram_cs = 0;
      settle();
      n_checks++;
      if (fetch_q.size() == 0) $display("FAIL wr_readback_sb empty");
      else begin
         logic [63:0] e;
         e = fetch_q.pop_front();
         if (bus.instr_fromsram !== e) $display("FAIL wr_readback got %h exp %h", bus.instr_fromsram, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 9; i++) begin
         logic eg, elr, ecs;
         eg = (i % 3 == 0); elr = (i % 3 != 0); ecs = (i % 3 != 2);
         tick();
         bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_adr = 32'h80;
         bus.isram_cs = 1; bus.isram_adr = 29'h10;
         settle();
         n_checks++; if (bus.lsu_gnt !== eg) $display("FAIL b2b_gnt[%0d] got %b exp %b", i, bus.lsu_gnt, eg); else n_pass++;
         n_checks++; if (bus.lr_isram_cs !== elr) $display("FAIL b2b_lr[%0d] got %b exp %b", i, bus.lr_isram_cs, elr); else n_pass++;
         n_checks++; if (mem_cs !== ecs) $display("FAIL b2b_mem_cs[%0d] got %b exp %b", i, mem_cs, ecs); else n_pass++;
         if (eg) lsu_q.push_back('{rdata: 32'h5566CCDD, err: 1'b0});
         if (i % 3 == 2) begin
            n_checks++;
            if (lsu_q.size() == 0 || bus.lsu_rvalid !== 1'b1) $display("FAIL b2b_rvalid[%0d] got %b exp 1", i, bus.lsu_rvalid);
            else begin
               lsu_exp_t e;
               e = lsu_q.pop_front();
               if ({bus.lsu_rdata, bus.lsu_err} !== e) $display("FAIL b2b_resp[%0d] got %h/%b exp %h/%b", i, bus.lsu_rdata, bus.lsu_err, e.rdata, e.err);
               else n_pass++;
            end
         end
         $display("b2b[%0d]: gnt=%b lr=%b mem_cs=%b rvalid=%b", i, bus.lsu_gnt, bus.lr_isram_cs, mem_cs, bus.lsu_rvalid);
      end
      tick();
      bus.lsu_req = 0; bus.isram_cs = 0;
   endtask

   task automatic test_region_err();
      logic [31:0] adrs [3];
      logic        errs [3];
      logic [31:0] dats [3];
      adrs[0] = 32'h0001_0000; errs[0] = 1'b1; dats[0] = 32'h0;
      adrs[1] = 32'h0000_FFFC; errs[1] = 1'b0; dats[1] = 32'hCAFEBABE;
      adrs[2] = 32'hFFFF_FFF0; errs[2] = 1'b1; dats[2] = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_adr = adrs[i];
         settle();
         n_checks++; if (bus.lsu_gnt !== 1'b1) $display("FAIL reg_gnt[%0d] got %b exp 1", i, bus.lsu_gnt); else n_pass++;
         lsu_q.push_back('{rdata: dats[i], err: errs[i]});
         tick();
         bus.lsu_req = 0;
         settle();
         n_checks++; if (mem_cs !== !errs[i]) $display("FAIL reg_mem_cs[%0d] got %b exp %b", i, mem_cs, !errs[i]); else n_pass++;
         tick();
         settle();
         n_checks++;
         if (lsu_q.size() == 0 || bus.lsu_rvalid !== 1'b1) $display("FAIL reg_rvalid[%0d] got %b exp 1", i, bus.lsu_rvalid);
         else begin
            lsu_exp_t e;
            e = lsu_q.pop_front();
            if ({bus.lsu_rdata, bus.lsu_err} !== e) $display("FAIL reg_resp[%0d] got %h/%b exp %h/%b", i, bus.lsu_rdata, bus.lsu_err, e.rdata, e.err);
            else n_pass++;
         end
         $display("region: adr=%h rdata=%h err=%b", adrs[i], bus.lsu_rdata, bus.lsu_err);
      end
   endtask

   task automatic test_reset_abort();
      tick();
      bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_adr = 32'h80; bus.isram_cs = 0;
      settle();
      n_checks++; if (bus.lsu_gnt !== 1'b1) $display("FAIL abort_gnt got %b exp 1", bus.lsu_gnt); else n_pass++;
      tick();
      bus.lsu_req = 0;
      settle();
      n_checks++; if (bus.lr_isram_cs !== 1'b1) $display("FAIL abort_in_acc got %b exp 1", bus.lr_isram_cs); else n_pass++;
      cpurst_n = 0; bus.isram_cs = 1; bus.isram_adr = 29'h10;
      #1;
      n_checks++; if (mem_cs !== 1'b1) $display("FAIL abort_mem_cs got %b exp 1", mem_cs); else n_pass++;
      n_checks++; if ({bus.lr_isram_cs, bus.lr_isram_cs_ff} !== 2'b00) $display("FAIL abort_lr got %b exp 00", {bus.lr_isram_cs, bus.lr_isram_cs_ff}); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         n_checks++; if (bus.lsu_rvalid !== 1'b0) $display("FAIL abort_rvalid[%0d] got %b exp 0", i, bus.lsu_rvalid); else n_pass++;
      end
      tick();
      cpurst_n = 1; bus.isram_cs = 0;
      tick();
      bus.lsu_req = 1; bus.lsu_adr = 32'h80;
      settle();
      n_checks++; if (bus.lsu_gnt !== 1'b1) $display("FAIL abort_regnt got %b exp 1", bus.lsu_gnt); else n_pass++;
      lsu_q.push_back('{rdata: 32'h5566CCDD, err: 1'b0});
      tick();
      bus.lsu_req = 0;
      tick();
      settle();
      n_checks++;
      if (lsu_q.size() == 0 || bus.lsu_rvalid !== 1'b1) $display("FAIL abort_post_rvalid got %b exp 1", bus.lsu_rvalid);
      else begin
         lsu_exp_t e;
         e = lsu_q.pop_front();
         if ({bus.lsu_rdata, bus.lsu_err} !== e) $display("FAIL abort_post_resp got %h/%b exp %h/%b", bus.lsu_rdata, bus.lsu_err, e.rdata, e.err);
         else n_pass++;
      end
      $display("abort: post-reset rdata=%h rvalid=%b", bus.lsu_rdata, bus.lsu_rvalid);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fetch();
      test_lsu_read();
      test_lsu_write();
      test_back_to_back();
      test_region_err();
      test_reset_abort();
      n_checks++;
      if (lsu_q.size() != 0 || fetch_q.size() != 0) $display("FAIL sb_drain got %0d/%0d exp 0/0", lsu_q.size(), fetch_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/isram_ctrl.md
Name: isram_ctrl

Overview:
Responder side of the instruction-SRAM fetch interface. Serves 64-bit fetch reads (isram_cs / isram_adr / instr_fromsram) from a single-port 64-bit SRAM macro. Lets the load/store unit take the macro for 32-bit data reads and writes. Generates lr_isram_cs and lr_isram_cs_ff, which the fetch stage uses to stall and to hold its last instruction word.

Parameters:
ISRAM_AW, 13, macro address width in doublewords (64 KB default)
ISRAM_BASE, 32'h0000_0000, byte base address of the ISRAM region for LSU accesses

Ports:
clk  in  1  core clock
cpurst_n  in  1  asynchronous active-low reset
isram_cs  in  1  fetch read request
isram_adr  in  [31:3]  fetch doubleword address
instr_fromsram  out  64  fetch read data, one cycle after the request
lsu_req  in  1  LSU access request, held until granted
lsu_we  in  1  1 = write, 0 = read
lsu_adr  in  32  LSU byte address
lsu_wdata  in  32  LSU write data
lsu_be  in  4  LSU byte enables
lsu_gnt  out  1  request accepted this cycle
lsu_rvalid  out  1  response valid, one-cycle pulse
lsu_rdata  out  32  read data; 0 for writes and errors
lsu_err  out  1  out-of-region access; valid with lsu_rvalid
lr_isram_cs  out  1  macro owned by LSU, fetch must stall
lr_isram_cs_ff  out  1  lr_isram_cs delayed one cycle
mem_cs  out  1  macro chip select
mem_we  out  1  macro write enable
mem_adr  out  ISRAM_AW  macro doubleword address
mem_wdata  out  64  macro write data
mem_bwe  out  8  macro byte write enables
mem_rdata  in  64  macro read data, one-cycle latency

Behaviour:
- Reset (cpurst_n low, async) forces:
  - state IDLE
  - lr_isram_cs = 0, lr_isram_cs_ff = 0
  - lsu_rvalid = 0, lsu_err = 0, lsu_rdata = 0
  - all captured request registers = 0
- instr_fromsram = mem_rdata, passthrough with no register.
- FSM states: IDLE, LS_ACC, LS_RSP.
- IDLE:
  - lsu_gnt = lsu_req (combinational).
  - Macro serves fetch: mem_cs = isram_cs, mem_we = 0, mem_adr = isram_adr[ISRAM_AW+2:3]. Higher fetch address bits are ignored (aliasing).
  - On lsu_req, capture we, adr, wdata, be and the region-error flag, then go to LS_ACC.
- LS_ACC:
  - lr_isram_cs = 1 (registered); lsu_gnt = 0.
  - Macro is driven from the captured request: mem_cs = ~err_r, mem_we = we_r, mem_adr = adr_r[ISRAM_AW+2:3].
  - instr_fromsram still carries the fetch read issued in the previous IDLE cycle; fetch captures it on lr_isram_cs rising.
  - Always go to LS_RSP.
- LS_RSP:
  - lr_isram_cs = 1, mem_cs = 0, lsu_gnt = 0.
  - lsu_rvalid = 1. lsu_err = err_r.
  - lsu_rdata = adr_r[2] ? mem_rdata[63:32] : mem_rdata[31:0] for a non-error read; otherwise 0.
  - Always go to IDLE.
- Fairness: at least one IDLE cycle separates LSU operations, so fetch gets every third macro slot under continuous LSU pressure. An LSU op occupies 2 cycles; grant-to-rvalid is 2 cycles.
- lr_isram_cs_ff is lr_isram_cs registered, so it stays high for the first IDLE cycle after an op. Fetch uses its held word in that cycle while re-issuing its read.
- Write lane selection:
  - mem_wdata = {wdata_r, wdata_r}.
  - mem_bwe = adr_r[2] ? {be_r, 4'h0} : {4'h0, be_r}.
  - be_r = 0 gives a macro cycle with no bytes written; this is legal.
- Region check:
  - err = ((lsu_adr - ISRAM_BASE) >> (ISRAM_AW+3)) != 0, using 32-bit unsigned wrap.
  - An erroring op keeps identical FSM timing, asserts no mem_cs, and returns lsu_rdata = 0.
- lsu_adr[1:0] is ignored; byte placement is the LSU's responsibility.
- If reset is asserted during LS_ACC or LS_RSP, the op is aborted immediately:
  - mem_cs falls asynchronously with the state.
  - No lsu_rvalid is produced.
  - lr_isram_cs and lr_isram_cs_ff are cleared.
- isram_cs is ignored outside IDLE. Fetch is stalled by lr_isram_cs and must re-issue its request.

Test Plan:
1. Preload mem[0x10] = 64'h1122334455667788; in IDLE drive isram_cs = 1, isram_adr = 29'h10 -> same cycle mem_cs = 1, mem_adr = 0x10; next cycle instr_fromsram = 64'h1122334455667788.
2. With the same preload, pulse lsu_req with lsu_we = 0, lsu_adr = 0x84 at cycle T:
   - lsu_gnt = 1 at T.
   - At T+1: lr_isram_cs = 1, mem_cs = 1, mem_adr = 0x10, mem_we = 0.
   - At T+2: lsu_rvalid = 1, lsu_rdata = 32'h11223344, lsu_err = 0.
   - lr_isram_cs_ff = 1 at T+2 and T+3.
3. LSU write with lsu_adr = 0x80, lsu_be = 4'b0011, lsu_wdata = 32'hAABBCCDD -> at T+1 mem_we = 1, mem_bwe = 8'h03, mem_wdata = 64'hAABBCCDDAABBCCDD; at T+2 lsu_rvalid = 1, lsu_rdata = 0.
4. Hold lsu_req high for 9 cycles with isram_cs = 1 -> lsu_gnt pattern 1,0,0,1,0,0,1,0,0; lr_isram_cs pattern 0,1,1,0,1,1,0,1,1; mem_cs = 1 in every cycle except LS_RSP cycles.
5. With ISRAM_AW = 13 and ISRAM_BASE = 0, LSU read at lsu_adr = 32'h0001_0000 -> mem_cs = 0 at T+1; at T+2 lsu_rvalid = 1, lsu_err = 1, lsu_rdata = 0.
6. Drop cpurst_n mid-LS_ACC -> same cycle mem_cs follows isram_cs and lr_isram_cs = 0; lsu_rvalid never asserts; after release a new lsu_req is granted normally.
